fc_score_collector: RTL and testbench
=====================================

Name: fc_score_collector

Overview:
- Producer side of the argmax comparator handshake in the BNN OCR datapath.
- Accepts the fully-connected layer's per-class Q8.8 scores as a serial stream and assembles them into a parallel array.
- Holds the array stable with a level "scores ready" strobe while the comparator scans it, then captures the winning class.
- Releases the comparator and hands the class downstream over a valid/ready interface.

Parameters:
- IC, 10: number of classes, i.e. the number of scores per frame.
- OUTPUT_BIT, $clog2(IC+1): width of the class index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  score beat valid.
- s_ready  out  1  collector can accept a beat.
- s_data  in  16  signed Q8.8 score for the current class index.
- s_last  in  1  producer marks the final beat of a frame.
- scores  out  16 x IC  signed Q8.8 array [0:IC-1], to the comparator data input.
- scores_ready  out  1  level strobe to the comparator's data_in_ready; array is stable while high.
- cmp_class  in  OUTPUT_BIT  comparator argmax output.
- cmp_done  in  1  comparator data_out_ready; cmp_class is valid while high.
- res_valid  out  1  classification result valid.
- res_ready  in  1  downstream accepts the result.
- res_class  out  OUTPUT_BIT  classification result.
- frame_err  out  1  sticky framing error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FILL, idx=0, scores all 0, scores_ready=0, res_valid=0, res_class=0, frame_err=0.
  - No beat is accepted while rst_n is low.
- States: FILL, HOLD, RELEASE.
- FILL:
  - s_ready=1. A beat transfers when s_valid && s_ready at a clock edge: scores[idx]<=s_data, idx<=idx+1.
  - On the transfer with idx==IC-1: idx<=0, scores_ready<=1, go to HOLD.
  - scores_ready is registered, so it is first high the cycle after the last beat.
- Framing:
  - The beat count alone closes the frame. s_last is checked only.
  - frame_err<=1 if s_last=1 on a beat with idx!=IC-1, or s_last=0 on the beat with idx==IC-1.
  - frame_err is sticky until reset.
- HOLD:
  - s_ready=0. scores and scores_ready are held constant.
  - When cmp_done=1 and (res_valid==0 or res_ready==1):
    - res_class<=cmp_class, res_valid<=1.
    - scores_ready<=0; go to RELEASE.
  - When cmp_done=1 but the previous result is still pending (res_valid=1, res_ready=0): stay in HOLD, keep scores_ready high, no capture.
- RELEASE:
  - Exactly one cycle with scores_ready=0, which clears the comparator.
  - s_ready=0 during this cycle. Go to FILL.
- Result interface:
  - res_valid clears on an edge where res_valid && res_ready, unless a new capture occurs on the same edge. In that case res_valid stays 1 and res_class takes the new value.
  - res_class is stable while res_valid=1 && res_ready=0.
- Latency: last beat edge -> scores_ready high next cycle. cmp_done sampled high -> res_valid high next cycle. Minimum frame-to-frame period is IC + comparator scan + 2 cycles.
- cmp_done seen in FILL or RELEASE is ignored.
- Arithmetic: scores are stored verbatim. No sign extension or saturation.
- Reset mid-operation: any state returns immediately to FILL. A partial frame is discarded and a pending result is lost.

Decomposition:
- Shared package bnn_pkg holds:
  - typedef q8_8_t (logic signed [15:0]).
  - NUM_CLASSES=10.
  - CLASS_W=$clog2(NUM_CLASSES+1).
  - State enum fc_collect_state_t {FILL, HOLD, RELEASE}.
- Single module; no sub-module. The score array is a plain register file inside the collector.

Test Plan:
- Frame of 10 beats, all 16'h0010 except index 7 = 16'h0300, comparator attached -> scores_ready high 1 cycle after beat 10; res_class=7, res_valid=1 until res_ready.
- All-negative frame, all 16'hFF00 except index 3 = 16'hFFFF, with s_last on beat 10 -> res_class=3, frame_err=0.
- Backpressure:
  - Stimulus: res_ready=0 after a frame yielding 7; stream a second frame yielding 2.
  - Expected: HOLD persists, scores_ready stays high, s_ready=0, res_class stays 7.
  - On res_ready=1: 7 is consumed, then res_class=2 with res_valid continuous.
- s_last asserted on beat 5 of 10 -> frame_err=1 from the next cycle, still collects 10 beats, result produced normally; frame_err remains 1 on the next clean frame.
- s_valid held high during HOLD/RELEASE with changing s_data -> no writes to scores; beats transfer only once back in FILL; RELEASE lasts exactly 1 cycle with scores_ready=0.
- rst_n pulsed low mid-HOLD (scores_ready=1, res_valid=1) -> both 0 immediately without a clock; next clean frame with max at index 0 -> res_class=0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN OCR datapath.
// Q8.8 score type, class count and collector state encoding.
package bnn_pkg;

  typedef logic signed [15:0] q8_8_t;

  localparam int NUM_CLASSES = 10;
  localparam int CLASS_W = $clog2(NUM_CLASSES + 1);

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    RELEASE
  } fc_collect_state_t;

endpackage

// File: rtl/fc_score_collector_if.sv
// Score stream in / class result out handshakes of the collector.
// master = producer + result consumer, slave = collector.
interface fc_score_collector_if
  import bnn_pkg::*;
#(
  parameter int OUTPUT_BIT = CLASS_W
) ();

  logic                  s_valid;
  logic                  s_ready;
  q8_8_t                 s_data;
  logic                  s_last;
  logic                  res_valid;
  logic                  res_ready;
  logic [OUTPUT_BIT-1:0] res_class;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output res_ready,
    input  s_ready,
    input  res_valid,
    input  res_class
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  res_ready,
    output s_ready,
    output res_valid,
    output res_class
  );

endinterface

// File: rtl/fc_score_collector.sv
// Collects serial FC scores into a parallel array for the argmax
// comparator, then forwards the winning class over valid/ready.
module fc_score_collector
  import bnn_pkg::*;
#(
  parameter int IC         = NUM_CLASSES,
  parameter int OUTPUT_BIT = $clog2(IC + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fc_score_collector_if.slave   bus,
  output q8_8_t                 scores [0:IC-1],
  output logic                  scores_ready,
  input  logic [OUTPUT_BIT-1:0] cmp_class,
  input  logic                  cmp_done,
  output logic                  frame_err
);

  localparam int IW = (IC > 1) ? $clog2(IC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(IC - 1);

  fc_collect_state_t     r_state;
  fc_collect_state_t     w_next;
  logic [IW-1:0]         r_idx;
  q8_8_t                 r_scores [0:IC-1];
  logic                  r_scores_ready;
  logic                  r_res_valid;
  logic [OUTPUT_BIT-1:0] r_res_class;
  logic                  r_frame_err;

  logic w_s_ready;
  logic w_beat;
  logic w_last;
  logic w_cap;

  always_comb begin
    w_next    = r_state;
    w_s_ready = (r_state == FILL);
    w_beat    = bus.s_valid && w_s_ready;
    w_last    = (r_idx == LAST_IDX);
    // a pending unaccepted result blocks capture, keeping the array held
    w_cap     = (r_state == HOLD) && cmp_done
              && (!r_res_valid || bus.res_ready);
    unique case (r_state)
      FILL:    if (w_beat && w_last) w_next = HOLD;
      HOLD:    if (w_cap) w_next = RELEASE;
      RELEASE: w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_idx   <= '0;
      for (int i = 0; i < IC; i++) r_scores[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_beat) begin
        r_scores[r_idx] <= bus.s_data;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scores_ready <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      if (w_beat && w_last) r_scores_ready <= 1'b1;
      else if (w_cap) r_scores_ready <= 1'b0;
      if (w_beat && (bus.s_last != w_last)) r_frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_class <= '0;
    end else if (w_cap) begin
      r_res_valid <= 1'b1;
      r_res_class <= cmp_class;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_class = r_res_class;
  assign scores        = r_scores;
  assign scores_ready  = r_scores_ready;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_fc_score_collector.sv
// Directed + randomized bench for fc_score_collector, acting as
// producer, argmax comparator and result consumer.
module tb_fc_score_collector;
  import bnn_pkg::*;

  localparam int IC = NUM_CLASSES;

  logic               clk = 1'b0;
  logic               rst_n;
  q8_8_t              scores [0:IC-1];
  logic               scores_ready;
  logic [CLASS_W-1:0] cmp_class;
  logic               cmp_done;
  logic               frame_err;

  fc_score_collector_if #(.OUTPUT_BIT(CLASS_W)) bus ();

  fc_score_collector #(
    .IC(IC),
    .OUTPUT_BIT(CLASS_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .scores(scores),
    .scores_ready(scores_ready),
    .cmp_class(cmp_class),
    .cmp_done(cmp_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  q8_8_t m_frame [IC];
  logic  m_err;
  int    exp_cls;
  int    prev_cls;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference comparator: first index holding the largest signed score
  function automatic int argmax();
    int b = 0;
    for (int i = 1; i < IC; i++)
      if (m_frame[i] > m_frame[b]) b = i;
    return b;
  endfunction

  task automatic rand_frame(int peak);
    for (int i = 0; i < IC; i++) begin
      if (peak >= 0) m_frame[i] = q8_8_t'($urandom_range(0, 255));
      else m_frame[i] = q8_8_t'($urandom);
    end
    if (peak >= 0) m_frame[peak] = 16'h0300;
  endtask

  task automatic check_scores(string tag);
    for (int i = 0; i < IC; i++)
      check(tag, 32'(scores[i]), 32'(m_frame[i]));
  endtask

  task automatic send_beat(q8_8_t d, logic l);
    int n = 0;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s_ready wait", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(int first, int lastpos);
    for (int i = first; i < IC; i++) begin
      check("pre-last scores_ready", 32'(scores_ready), 32'd0);
      send_beat(m_frame[i], 1'(i == lastpos));
      m_err = m_err | ((i == lastpos) != (i == IC - 1));
      check("frame_err", 32'(frame_err), 32'(m_err));
    end
  endtask

  task automatic cmp_capture(int delay);
    check("hold scores_ready", 32'(scores_ready), 32'd1);
    repeat (delay) begin
      @(negedge clk);
      check("hold scores_ready", 32'(scores_ready), 32'd1);
      check("hold s_ready", 32'(bus.s_ready), 32'd0);
    end
    cmp_class = CLASS_W'(argmax());
    cmp_done  = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_frame(int delay, int holdoff);
    int e;
    check("last scores_ready", 32'(scores_ready), 32'd1);
    check("hold s_ready", 32'(bus.s_ready), 32'd0);
    check_scores("scores");
    e = argmax();
    cmp_capture(delay);
    check("res_valid", 32'(bus.res_valid), 32'd1);
    check("res_class", 32'(bus.res_class), 32'(e));
    check("release scores_ready", 32'(scores_ready), 32'd0);
    check("release s_ready", 32'(bus.s_ready), 32'd0);
    cmp_done  = 1'b0;
    cmp_class = CLASS_W'($urandom);
    @(negedge clk);
    check("fill s_ready", 32'(bus.s_ready), 32'd1);
    check("fill scores_ready", 32'(scores_ready), 32'd0);
    repeat (holdoff) begin
      cmp_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("stall res_valid", 32'(bus.res_valid), 32'd1);
      check("stall res_class", 32'(bus.res_class), 32'(e));
    end
    cmp_done = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("consumed res_valid", 32'(bus.res_valid), 32'd0);
  endtask

  task automatic run_frame(int lastpos, int delay, int holdoff);
    send_frame(0, lastpos);
    finish_frame(delay, holdoff);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.s_valid   = 1'b1;
    bus.s_data    = 16'h1234;
    bus.s_last    = 1'b0;
    bus.res_ready = 1'b0;
    cmp_done      = 1'b0;
    cmp_class     = '0;
    m_err         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst scores_ready", 32'(scores_ready), 32'd0);
    check("rst res_valid", 32'(bus.res_valid), 32'd0);
    check("rst res_class", 32'(bus.res_class), 32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
    check("rst scores0", 32'(scores[0]), 32'd0);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // peak at 7 among small positives
    for (int i = 0; i < IC; i++) m_frame[i] = 16'h0010;
    m_frame[7] = 16'h0300;
    check("t1 model peak", 32'(argmax()), 32'd7);
    run_frame(IC - 1, 2, 3);

    // all negative, least negative at 3
    for (int i = 0; i < IC; i++) m_frame[i] = 16'hFF00;
    m_frame[3] = 16'hFFFF;
    run_frame(IC - 1, 0, 0);
    check("t2 frame_err", 32'(frame_err), 32'd0);

    repeat (6) begin
      rand_frame(-1);
      run_frame(IC - 1, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // backpressure: result 7 unconsumed while frame with peak 2 arrives
    rand_frame(7);
    send_frame(0, IC - 1);
    check_scores("bp scores a");
    cmp_capture(1);
    check("bp res_class a", 32'(bus.res_class), 32'd7);
    cmp_done = 1'b0;
    @(negedge clk);
    rand_frame(2);
    send_frame(0, IC - 1);
    cmp_class = CLASS_W'(argmax());
    cmp_done  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp scores_ready", 32'(scores_ready), 32'd1);
      check("bp s_ready", 32'(bus.s_ready), 32'd0);
      check("bp res_valid", 32'(bus.res_valid), 32'd1);
      check("bp res_class old", 32'(bus.res_class), 32'd7);
      check_scores("bp scores b");
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp res_valid swap", 32'(bus.res_valid), 32'd1);
    check("bp res_class new", 32'(bus.res_class), 32'd2);
    check("bp release", 32'(scores_ready), 32'd0);
    cmp_done = 1'b0;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("bp res_valid hold", 32'(bus.res_valid), 32'd1);
    check("bp res_class hold", 32'(bus.res_class), 32'd2);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("bp consumed", 32'(bus.res_valid), 32'd0);

    // s_valid held through HOLD and RELEASE with junk data
    rand_frame(5);
    send_frame(0, IC - 1);
    repeat (3) begin
      bus.s_valid = 1'b1;
      bus.s_data  = q8_8_t'($urandom);
      bus.s_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("sv hold s_ready", 32'(bus.s_ready), 32'd0);
      check("sv hold scores_ready", 32'(scores_ready), 32'd1);
      check("sv frame_err", 32'(frame_err), 32'(m_err));
      check_scores("sv hold scores");
    end
    cmp_class = CLASS_W'(argmax());
    cmp_done  = 1'b1;
    bus.s_data = q8_8_t'($urandom);
    @(negedge clk);
    check("sv release scores_ready", 32'(scores_ready), 32'd0);
    check("sv release s_ready", 32'(bus.s_ready), 32'd0);
    check("sv res_class", 32'(bus.res_class), 32'd5);
    check_scores("sv release scores");
    cmp_done = 1'b0;
    bus.s_data = q8_8_t'($urandom);
    bus.s_last = 1'b0;
    @(negedge clk);
    check("sv fill s_ready", 32'(bus.s_ready), 32'd1);
    check("sv fill scores_ready", 32'(scores_ready), 32'd0);
    check_scores("sv fill scores");
    rand_frame(8);
    bus.s_data = m_frame[0];
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.res_ready = 1'b0;
    check("sv first beat", 32'(scores[0]), 32'(m_frame[0]));
    check("sv consumed", 32'(bus.res_valid), 32'd0);
    send_frame(1, IC - 1);
    finish_frame(1, 1);

    // early s_last on beat 5, then a clean frame keeps the flag
    rand_frame(-1);
    run_frame(4, 1, 1);
    check("err sticky a", 32'(frame_err), 32'd1);
    rand_frame(1);
    run_frame(IC - 1, 0, 0);
    check("err sticky b", 32'(frame_err), 32'd1);

    // async reset while holding with a pending result
    rand_frame(6);
    send_frame(0, IC - 1);
    cmp_capture(0);
    cmp_done = 1'b0;
    @(negedge clk);
    rand_frame(4);
    send_frame(0, IC - 1);
    check("pre-rst scores_ready", 32'(scores_ready), 32'd1);
    check("pre-rst res_valid", 32'(bus.res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst scores_ready", 32'(scores_ready), 32'd0);
    check("mid-rst res_valid", 32'(bus.res_valid), 32'd0);
    check("mid-rst frame_err", 32'(frame_err), 32'd0);
    check("mid-rst scores4", 32'(scores[4]), 32'd0);
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_frame(-1);
    m_frame[0] = 16'h7FFF;
    check("post-rst model peak", 32'(argmax()), 32'd0);
    run_frame(IC - 1, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
